// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the front end.
// XLEN      : default PC / address width
// NOP_INSTR : canonical NOP (addi x0,x0,0), also the IF/ID flush value
// PC_INCR   : byte step between sequential instruction fetches
package pipe_pkg;
    localparam int unsigned XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_INCR   = 4;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc} entries.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   enq/enq_data: push one entry
//   deq         : pop the head entry
//   flush       : empty the queue (wins over enq/deq)
//   full, empty : occupancy flags
//   count       : number of valid entries
//   head        : oldest entry (undefined when empty)
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned WIDTH  = 32 + XLEN,
    localparam int unsigned AW    = $clog2(QDEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [CW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    wptr_d, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + 1'b1;
            if (deq) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // When full with enq+deq together the write lands on the slot being
    // popped; the head was already consumed combinationally this cycle.
    always_ff @(posedge clk) begin
        if (enq && !flush) mem_q[wptr_q[AW-1:0]] <= enq_data;
    end

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (count == CW'(QDEPTH));
    assign head  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   imem_req_*        : in-order fetch requests (valid/ready, addr = fetch PC)
//   imem_resp_*       : in-order responses (valid only)
//   redirect_valid/pc : taken branch/jump; flush and refetch from redirect_pc
//   stall             : IF/ID holding; keep the head entry
//   instr_out/pc_out  : head {instr, pc}, NOP/0 when nothing is queued
//   instr_valid       : instr_out/pc_out carry a real queued instruction
module if_fetch_unit
#(
    parameter int unsigned      XLEN     = pipe_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid
);
    import pipe_pkg::NOP_INSTR;
    import pipe_pkg::PC_INCR;

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            q_enq, q_deq, q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic [32+XLEN-1:0] q_head;

    logic [CW:0]     used;
    logic            hs;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (32 + XLEN)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq      (q_enq),
        .enq_data ({imem_resp_data, resp_pc_q}),
        .deq      (q_deq),
        .flush    (redirect_valid),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count),
        .head     (q_head)
    );

    always_comb begin
        // Queued entries plus every in-flight request (stale ones included)
        // must fit in the queue, so an accepted response can always enqueue.
        used           = {1'b0, q_count} + {1'b0, out_q};
        imem_req_valid = !reset && !redirect_valid && (used < QD);
        hs             = imem_req_valid && imem_req_ready;

        q_enq = imem_resp_valid && (drop_q == '0) && !redirect_valid;
        q_deq = !q_empty && !stall && !redirect_valid;

        out_d = out_q + CW'(hs) - CW'(imem_resp_valid);

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still in flight is wrong-path, including a response
            // landing this very cycle (which is not counted since it is here).
            drop_d     = out_q - CW'(imem_resp_valid);
        end else begin
            if (hs)    fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
            if (q_enq) resp_pc_d  = resp_pc_q + XLEN'(PC_INCR);
            if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid   = !q_empty;
    assign instr_out     = q_empty ? NOP_INSTR : q_head[XLEN +: 32];
    assign pc_out        = q_empty ? '0 : q_head[XLEN-1:0];

    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (out_q != '0));
    a_out_bound: assert property (@(posedge clk) disable iff (reset)
        out_q <= CW'(QDEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (reset)
        drop_q <= CW'(QDEPTH));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        q_count <= CW'(QDEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        q_enq |-> (!q_full || q_deq));

endmodule
